// File: rtl/window_generator.sv
// 3x3 raster window generator with edge replication.
// Two line buffers hold the previous two rows; two column registers plus the
// incoming column form the neighbourhood. One output register carries the
// window under a valid/stall handshake.
//
// Handshake: a pixel moves when in_valid && in_ready; a window moves when
// out_valid && !stall. While out_valid && stall the output register is full,
// so in_ready drops and nothing inside advances.
module window_generator #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      pixel_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            stall,
  output logic [8:0][7:0] window,
  output logic            out_valid,
  output logic            frame_done,
  output logic [1:0]      dbg_state_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    EDGE   = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  // One column of the neighbourhood: rows r-1, r, r+1.
  typedef struct packed {
    logic [7:0] bot;
    logic [7:0] mid;
    logic [7:0] top;
  } col_t;

  typedef logic [8:0][7:0] win_t;

  // Assemble a window from left, centre and right columns.
  function automatic win_t make_win(input col_t l, input col_t c, input col_t r);
    win_t w;
    w[0] = l.top; w[1] = c.top; w[2] = r.top;
    w[3] = l.mid; w[4] = c.mid; w[5] = r.mid;
    w[6] = l.bot; w[7] = c.bot; w[8] = r.bot;
    return w;
  endfunction

  state_t        state_q;
  logic [RW-1:0] row_q;        // row index of the pixel being accepted
  logic [CW-1:0] col_q;        // column being accepted (or read in FLUSH)
  col_t          col_a_q;      // column k-2
  col_t          col_b_q;      // column k-1
  logic          tail_q;       // FLUSH: all columns read, last window pending
  logic          run_q;        // first clock after reset release seen
  logic          last_q;       // output register holds window (H-1, W-1)
  logic          out_valid_q;
  win_t          win_q;

  logic [7:0] lb_top_q [IMG_W];  // row r-1
  logic [7:0] lb_mid_q [IMG_W];  // row r

  logic       can_load;
  logic       accept;
  logic [7:0] lb_top_rd;
  logic [7:0] lb_mid_rd;
  col_t       stream_col_d;
  col_t       flush_col_d;

  assign can_load    = !out_valid_q || !stall;
  assign in_ready    = run_q && can_load && (state_q == FILL || state_q == STREAM);
  assign accept      = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign window      = win_q;
  assign frame_done  = out_valid_q && last_q && !stall;
  assign dbg_state_o = state_q;

  // New column from line buffers: top row clamps to row 0 while emitting row 0;
  // in FLUSH the bottom row replicates the last image row.
  always_comb begin
    lb_top_rd        = lb_top_q[col_q];
    lb_mid_rd        = lb_mid_q[col_q];
    stream_col_d.top = (row_q == ROW_ONE) ? lb_mid_rd : lb_top_rd;
    stream_col_d.mid = lb_mid_rd;
    stream_col_d.bot = pixel_in;
    flush_col_d.top  = lb_top_rd;
    flush_col_d.mid  = lb_mid_rd;
    flush_col_d.bot  = lb_mid_rd;
  end

  // Line buffers shift down one row at each accepted column; reads see old data.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top_q[col_q] <= lb_mid_q[col_q];
      lb_mid_q[col_q] <= pixel_in;
    end
  end

  // Control FSM, counters, column registers and output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      row_q       <= '0;
      col_q       <= '0;
      col_a_q     <= '0;
      col_b_q     <= '0;
      tail_q      <= 1'b0;
      run_q       <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      win_q       <= '0;
    end else begin
      run_q <= 1'b1;
      if (out_valid_q && !stall) begin
        out_valid_q <= 1'b0;
        last_q      <= 1'b0;
      end
      case (state_q)
        FILL: begin
          if (accept) begin
            if (col_q == COL_LAST) begin
              col_q   <= '0;
              row_q   <= ROW_ONE;
              state_q <= STREAM;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            col_a_q <= col_b_q;
            col_b_q <= stream_col_d;
            if (col_q != '0) begin
              win_q       <= make_win((col_q == CW'(1)) ? col_b_q : col_a_q,
                                      col_b_q, stream_col_d);
              out_valid_q <= 1'b1;
            end
            if (col_q == COL_LAST) begin
              col_q   <= '0;
              state_q <= EDGE;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        EDGE: begin
          if (can_load) begin
            win_q       <= make_win(col_a_q, col_b_q, col_b_q);
            out_valid_q <= 1'b1;
            if (row_q == ROW_LAST) begin
              // Prime column 0 of the bottom row so FLUSH emits every cycle.
              col_b_q <= flush_col_d;
              col_q   <= CW'(1);
              state_q <= FLUSH;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= STREAM;
            end
          end
        end
        FLUSH: begin
          if (can_load) begin
            out_valid_q <= 1'b1;
            if (!tail_q) begin
              win_q   <= make_win((col_q == CW'(1)) ? col_b_q : col_a_q,
                                  col_b_q, flush_col_d);
              col_a_q <= col_b_q;
              col_b_q <= flush_col_d;
              if (col_q == COL_LAST) begin
                col_q  <= '0;
                tail_q <= 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end else begin
              win_q   <= make_win(col_a_q, col_b_q, col_b_q);
              last_q  <= 1'b1;
              tail_q  <= 1'b0;
              row_q   <= '0;
              col_q   <= '0;
              state_q <= FILL;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_window_generator.sv
// Bench for window_generator: a 4x3 instance for directed cases and a default
// 128x128 instance for back-to-back frames. A neighbourhood model builds the
// expected window stream from the image; one monitor checks every cycle.
module tb_window_generator;

  logic            clk = 1'b0;
  logic            rst_n [2];
  logic [7:0]      px [2];
  logic            iv [2];
  logic            ir [2];
  logic            st [2];
  logic [8:0][7:0] win [2];
  logic            ov [2];
  logic            fd [2];
  logic [1:0]      dbg [2];

  logic            stall_force [2];
  logic            stall_rand [2];
  int              acc_cnt [2];
  int              got [2];
  int              fd_cnt [2];
  logic            hold_q [2];
  logic [71:0]     prev_win [2];

  logic [72:0] exp_q_s[$];   // {frame_done, window}, small instance
  logic [72:0] exp_q_b[$];   // big instance

  int n_chk = 0;
  int n_fail = 0;

  // Clock and DUTs
  always #5 clk = ~clk;

  window_generator #(.IMG_W(4), .IMG_H(3)) u_small (
    .clk(clk), .reset(rst_n[0]), .pixel_in(px[0]), .in_valid(iv[0]),
    .in_ready(ir[0]), .stall(st[0]), .window(win[0]), .out_valid(ov[0]),
    .frame_done(fd[0]), .dbg_state_o(dbg[0]));

  window_generator u_big (
    .clk(clk), .reset(rst_n[1]), .pixel_in(px[1]), .in_valid(iv[1]),
    .in_ready(ir[1]), .stall(st[1]), .window(win[1]), .out_valid(ov[1]),
    .frame_done(fd[1]), .dbg_state_o(dbg[1]));

  task automatic chk(input bit ok, input string name, input logic [79:0] act,
                     input logic [79:0] expv);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int fid, input int r, input int c);
    int v;
    case (mode)
      0:       v = 50;
      1:       v = 10 * r + c;
      default: v = r * 3 + c * 5 + fid * 64;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [71:0] pack9(input int a, input int b, input int c,
                                        input int d, input int e, input int f,
                                        input int g, input int h, input int k);
    return {k[7:0], h[7:0], g[7:0], f[7:0], e[7:0], d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Model: expected windows of rows 0..n_rows-1 (first n_cols of the last one).
  task automatic push_windows(input int i, input int w_, input int h_, input int mode,
                              input int fid, input int n_win);
    int n;
    n = 0;
    for (int r = 0; r < h_; r++) begin
      for (int c = 0; c < w_; c++) begin
        logic [72:0] e;
        e = '0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            e[((dr + 1) * 3 + (dc + 1)) * 8 +: 8] =
              pix(mode, fid, clampi(r + dr, h_ - 1), clampi(c + dc, w_ - 1));
        e[72] = (r == h_ - 1) && (c == w_ - 1);
        if (n < n_win) begin
          if (i == 0) exp_q_s.push_back(e);
          else        exp_q_b.push_back(e);
        end
        n++;
      end
    end
  endtask

  // Driver: offer one pixel until accepted, with optional random bubbles.
  task automatic send_pixel(input int i, input logic [7:0] p, input int gap);
    int  waited;
    bit  done;
    waited = 0;
    done   = 0;
    while (!done) begin
      @(negedge clk);
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
        iv[i] = 1'b0;
      end else begin
        iv[i] = 1'b1;
        px[i] = p;
        #1;
        if (ir[i]) begin
          done = 1;
          acc_cnt[i]++;
        end
      end
      waited++;
      if (!done && waited > 2000) begin
        chk(1'b0, "accept_timeout", 80'(waited), 80'(2000));
        done = 1;
      end
    end
  endtask

  task automatic send_frame(input int i, input int w_, input int h_, input int mode,
                            input int fid, input int gap, input int n_px);
    int n;
    n = 0;
    for (int r = 0; r < h_; r++)
      for (int c = 0; c < w_; c++) begin
        if (n < n_px) send_pixel(i, pix(mode, fid, r, c), gap);
        n++;
      end
    @(negedge clk);
    iv[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int k;
    int sz;
    k  = 0;
    sz = (i == 0) ? exp_q_s.size() : exp_q_b.size();
    while (sz != 0 && k < 5000) begin
      @(negedge clk);
      k++;
      sz = (i == 0) ? exp_q_s.size() : exp_q_b.size();
    end
    chk(sz == 0, "drain", 80'(sz), 80'(0));
    repeat (4) @(negedge clk);
  endtask

  // Stall generation: random or forced, changed on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      st[i] = stall_rand[i] ? ($urandom_range(0, 99) < 40) : stall_force[i];
  end

  // Scoreboard monitor: every cycle, both instances.
  always begin
    @(negedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        hold_q[i] = 1'b0;
      end else begin
        if (hold_q[i]) begin
          chk(ov[i] == 1'b1, "hold_valid", 80'(ov[i]), 80'(1));
          chk(win[i] == prev_win[i], "hold_window", 80'(win[i]), 80'(prev_win[i]));
        end
        if (ov[i] && st[i])
          chk(ir[i] == 1'b0, "ready_while_stalled", 80'(ir[i]), 80'(0));
        if (ov[i] && !st[i]) begin
          logic [72:0] e;
          int          sz;
          sz = (i == 0) ? exp_q_s.size() : exp_q_b.size();
          if (sz == 0) begin
            chk(1'b0, "unexpected_window", 80'(win[i]), 80'(0));
          end else begin
            e = (i == 0) ? exp_q_s.pop_front() : exp_q_b.pop_front();
            chk(win[i] == e[71:0], "window", 80'(win[i]), 80'(e[71:0]));
            chk(fd[i] == e[72], "frame_done", 80'(fd[i]), 80'(e[72]));
          end
          got[i]++;
          if (fd[i]) fd_cnt[i]++;
        end else begin
          chk(fd[i] == 1'b0, "frame_done_idle", 80'(fd[i]), 80'(0));
        end
        hold_q[i]   = ov[i] && st[i];
        prev_win[i] = win[i];
      end
    end
  end

  // Directed sequence
  initial begin
    int g0, f0, a0, k;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; iv[i] = 1'b0; px[i] = '0;
      stall_force[i] = 1'b0; stall_rand[i] = 1'b0; st[i] = 1'b0;
      acc_cnt[i] = 0; got[i] = 0; fd_cnt[i] = 0;
      hold_q[i] = 1'b0; prev_win[i] = '0;
    end

    // Reset values and in_ready rise
    repeat (3) @(negedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk(ir[i] == 1'b0, "rst_in_ready", 80'(ir[i]), 80'(0));
      chk(ov[i] == 1'b0, "rst_out_valid", 80'(ov[i]), 80'(0));
      chk(fd[i] == 1'b0, "rst_frame_done", 80'(fd[i]), 80'(0));
      chk(win[i] == '0, "rst_window", 80'(win[i]), 80'(0));
      chk(dbg[i] == 2'd0, "rst_state", 80'(dbg[i]), 80'(0));
    end
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    #1;
    chk(ir[0] == 1'b0, "ready_before_edge", 80'(ir[0]), 80'(0));
    @(posedge clk);
    #1;
    chk(ir[0] == 1'b1, "ready_after_edge", 80'(ir[0]), 80'(1));
    chk(ir[1] == 1'b1, "ready_after_edge_big", 80'(ir[1]), 80'(1));

    // Flat frame: twelve windows of 50, one frame_done
    push_windows(0, 4, 3, 0, 0, 12);
    chk(exp_q_s[11] == {1'b1, pack9(50, 50, 50, 50, 50, 50, 50, 50, 50)},
        "model_flat_last", 80'(exp_q_s[11]), 80'({1'b1, {9{8'd50}}}));
    g0 = got[0]; f0 = fd_cnt[0];
    send_frame(0, 4, 3, 0, 0, 0, 12);
    drain(0);
    chk(got[0] - g0 == 12, "flat_count", 80'(got[0] - g0), 80'(12));
    chk(fd_cnt[0] - f0 == 1, "flat_done", 80'(fd_cnt[0] - f0), 80'(1));

    // Ramp frame 10*r+c, corners pinned by hand
    push_windows(0, 4, 3, 1, 0, 12);
    chk(exp_q_s[0][71:0] == pack9(0, 0, 1, 0, 0, 1, 10, 10, 11), "model_ramp_first",
        80'(exp_q_s[0][71:0]), 80'(pack9(0, 0, 1, 0, 0, 1, 10, 10, 11)));
    chk(exp_q_s[11][71:0] == pack9(12, 13, 13, 22, 23, 23, 22, 23, 23), "model_ramp_last",
        80'(exp_q_s[11][71:0]), 80'(pack9(12, 13, 13, 22, 23, 23, 22, 23, 23)));
    g0 = got[0];
    send_frame(0, 4, 3, 1, 0, 0, 12);
    drain(0);
    chk(got[0] - g0 == 12, "ramp_count", 80'(got[0] - g0), 80'(12));

    // Five stalled cycles with a window pending
    push_windows(0, 4, 3, 1, 0, 12);
    g0 = got[0];
    fork
      send_frame(0, 4, 3, 1, 0, 0, 12);
      begin
        k = 0;
        @(posedge clk); #1;
        while (!ov[0] && k < 100) begin @(posedge clk); #1; k++; end
        chk(ov[0] == 1'b1, "stall_wait_valid", 80'(ov[0]), 80'(1));
        stall_force[0] = 1'b1;
        @(negedge clk); #3;
        a0 = acc_cnt[0];
        repeat (4) begin
          @(negedge clk); #3;
          chk(ov[0] == 1'b1, "stall_valid", 80'(ov[0]), 80'(1));
          chk(ir[0] == 1'b0, "stall_ready", 80'(ir[0]), 80'(0));
        end
        chk(acc_cnt[0] == a0, "stall_no_accept", 80'(acc_cnt[0]), 80'(a0));
        stall_force[0] = 1'b0;
      end
    join
    drain(0);
    chk(got[0] - g0 == 12, "stall_count", 80'(got[0] - g0), 80'(12));

    // Random bubbles and random stall
    push_windows(0, 4, 3, 1, 0, 12);
    g0 = got[0];
    stall_rand[0] = 1'b1;
    send_frame(0, 4, 3, 1, 0, 50, 12);
    drain(0);
    stall_rand[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk(got[0] - g0 == 12, "random_count", 80'(got[0] - g0), 80'(12));

    // Reset in the middle of row 1, then a fresh frame
    push_windows(0, 4, 3, 1, 0, 2);
    send_frame(0, 4, 3, 1, 0, 0, 7);
    drain(0);
    rst_n[0] = 1'b0;
    #2;
    chk(ov[0] == 1'b0, "midrst_out_valid", 80'(ov[0]), 80'(0));
    chk(ir[0] == 1'b0, "midrst_in_ready", 80'(ir[0]), 80'(0));
    chk(win[0] == '0, "midrst_window", 80'(win[0]), 80'(0));
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    push_windows(0, 4, 3, 2, 3, 12);
    g0 = got[0]; f0 = fd_cnt[0];
    send_frame(0, 4, 3, 2, 3, 0, 12);
    drain(0);
    chk(got[0] - g0 == 12, "post_reset_count", 80'(got[0] - g0), 80'(12));
    chk(fd_cnt[0] - f0 == 1, "post_reset_done", 80'(fd_cnt[0] - f0), 80'(1));

    // Two back-to-back 128x128 frames
    push_windows(1, 128, 128, 2, 1, 16384);
    push_windows(1, 128, 128, 2, 2, 16384);
    chk(exp_q_b[0][71:0] == pack9(64, 64, 69, 64, 64, 69, 67, 67, 72), "model_big_f1",
        80'(exp_q_b[0][71:0]), 80'(pack9(64, 64, 69, 64, 64, 69, 67, 67, 72)));
    chk(exp_q_b[16384][71:0] == pack9(128, 128, 133, 128, 128, 133, 131, 131, 136),
        "model_big_f2", 80'(exp_q_b[16384][71:0]),
        80'(pack9(128, 128, 133, 128, 128, 133, 131, 131, 136)));
    for (int f = 1; f <= 2; f++)
      for (int r = 0; r < 128; r++)
        for (int c = 0; c < 128; c++)
          send_pixel(1, pix(2, f, r, c), 0);
    @(negedge clk);
    iv[1] = 1'b0;
    drain(1);
    chk(got[1] == 32768, "big_count", 80'(got[1]), 80'(32768));
    chk(fd_cnt[1] == 2, "big_done", 80'(fd_cnt[1]), 80'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels (>= 3).
REQ-002 Parameter IMG_H, default 128, image height in rows (>= 3).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset asserted when reset = 0.
REQ-005 pixel_in  input  8  unsigned raster-order pixel from upstream.
REQ-006 in_valid  input  1  pixel_in holds a valid pixel.
REQ-007 in_ready  output  1  block accepts pixel_in this cycle; a pixel transfers when in_valid && in_ready.
REQ-008 stall  input  1  downstream smoothing stage cannot take a window this cycle.
REQ-009 window  output  8 x [8:0]  3x3 neighbourhood; [0..2] row r-1, [3..5] row r, [6..8] row r+1, each ordered col c-1, c, c+1.
REQ-010 out_valid  output  1  window is valid; a window transfers when out_valid && !stall.
REQ-011 frame_done  output  1  one-cycle pulse on the transfer of window (IMG_H-1, IMG_W-1).

Function
REQ-012 The block SHALL store two full rows in line buffers (2 x IMG_W x 8 bits) plus a 3x3 register window; no other frame storage.
REQ-013 The block SHALL emit exactly IMG_W*IMG_H windows per frame, one per pixel, in raster order (r, c).
REQ-014 Borders SHALL use edge replication: any row index < 0 or > IMG_H-1 and any col index < 0 or > IMG_W-1 is clamped to the nearest valid index.
REQ-015 FSM states: FILL, STREAM, EDGE, FLUSH; reset state FILL.
REQ-016 FILL: in_ready = 1; accepts row 0; no windows emitted; after pixel (0, IMG_W-1) -> STREAM.
REQ-017 STREAM: accepting pixel (r+1, k) with k >= 1 SHALL present window (r, k-1) with out_valid = 1 on the next cycle; accepting (r+1, 0) emits nothing.
REQ-018 STREAM: accepting pixel (r+1, IMG_W-1) -> EDGE; EDGE has in_ready = 0 and presents window (r, IMG_W-1) after the pending window transfers, then returns to STREAM, or to FLUSH if r+1 = IMG_H-1.
REQ-019 FLUSH: in_ready = 0; emits windows (IMG_H-1, 0..IMG_W-1) one per non-stalled cycle using replicated bottom row; after the last transfer -> FILL.
REQ-020 in_ready SHALL be 0 whenever out_valid && stall (output register full), and in EDGE and FLUSH.
REQ-021 While out_valid && stall, window and out_valid SHALL hold unchanged; no counter, buffer or FSM state advances.
REQ-022 in_valid = 0 in FILL/STREAM SHALL insert bubbles only; no pixel dropped or duplicated, pending out_valid unaffected.
REQ-023 Row counter 0..IMG_H-1 and column counter 0..IMG_W-1 SHALL wrap to 0 at frame end; back-to-back frames supported with no gap beyond FLUSH.
REQ-024 Line buffer writes and reads to the same column in one cycle SHALL return the old (previous-row) value.
REQ-025 Window values SHALL be copied unmodified (no arithmetic); all pixels unsigned 8-bit.

Reset
REQ-026 While reset = 0: in_ready = 0, out_valid = 0, frame_done = 0, all window entries = 0, counters = 0, state = FILL.
REQ-027 Deassertion of reset SHALL discard any partial frame; the next accepted pixel is (0, 0); line buffer contents need not be cleared.
REQ-028 in_ready SHALL rise to 1 on the first clock edge after reset deassertion.

Verification
REQ-029 IMG_W=4, IMG_H=3, all pixels 50, in_valid always 1, stall 0 -> exactly 12 windows, every entry 50, frame_done once on the 12th.
REQ-030 IMG_W=4, IMG_H=3, pixel = 10*r + c -> window (0,0) = {0,0,1,0,0,1,10,10,11}; window (2,3) = {12,13,13,22,23,23,22,23,23}.
REQ-031 stall held high 5 cycles while out_valid = 1 -> window and out_valid unchanged, in_ready = 0, no pixel accepted; sequence resumes with no loss.
REQ-032 Random in_valid gaps (50%) and random stall -> window stream identical to the no-gap run, 12 windows, raster order.
REQ-033 reset pulled low mid-row 1 of frame, then released and a full frame sent -> outputs zero during reset; next frame's 12 windows correct, no stale windows emitted.
REQ-034 Two back-to-back frames at default 128x128 -> 16384 windows each, two frame_done pulses, frame 2 window (0,0) built only from frame 2 pixels.
